// File: rtl/branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_resolve_queue                                          |
// | Purpose  : multi-port branch resolver feeding an in-order FIFO of        |
// |            resolutions that drains to the frontend over valid/ready.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module branch_resolve_queue #(
   parameter int NR_PORTS = 2,
   parameter int DEPTH    = 4,
   parameter int VLEN     = 39,
   parameter int CNT_W    = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic [NR_PORTS-1:0]      valid_i,
   output logic                     ready_o,
   input  logic [NR_PORTS-1:0]      is_branch_i,
   input  logic [NR_PORTS-1:0]      is_jalr_i,
   input  logic [NR_PORTS-1:0]      comp_res_i,
   input  logic [NR_PORTS-1:0]      is_compressed_i,
   input  logic [NR_PORTS*VLEN-1:0] pc_i,
   input  logic [NR_PORTS*VLEN-1:0] operand_a_i,
   input  logic [NR_PORTS*VLEN-1:0] imm_i,
   input  logic [NR_PORTS*3-1:0]    pred_cf_i,
   input  logic [NR_PORTS*VLEN-1:0] pred_addr_i,
   output logic [NR_PORTS*VLEN-1:0] result_o,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [VLEN-1:0]          res_pc_o,
   output logic [VLEN-1:0]          res_target_o,
   output logic                     res_taken_o,
   output logic                     res_mispredict_o,
   output logic [2:0]               res_cf_o,
   output logic                     res_exc_o,
   output logic [CNT_W-1:0]         mispredict_cnt_o
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_OCC_W = $clog2(DEPTH) + 1;
   localparam int c_NP_W  = $clog2(NR_PORTS + 1);

   localparam logic [c_PTR_W-1:0] c_PTR_MASK = c_PTR_W'(DEPTH - 1);
   localparam logic [2:0]         c_CF_NOCF   = 3'd0;
   localparam logic [2:0]         c_CF_BRANCH = 3'd1;
   localparam logic [2:0]         c_CF_JUMPR  = 3'd3;
   localparam logic [2:0]         c_CF_RETURN = 3'd4;

   // Per-port resolution results
   logic [NR_PORTS-1:0][VLEN-1:0] w_next_pc;
   logic [NR_PORTS-1:0][VLEN-1:0] w_res_tgt;
   logic [NR_PORTS-1:0][VLEN-1:0] w_port_pc;
   logic [NR_PORTS-1:0][2:0]      w_cf;
   logic [NR_PORTS-1:0]           w_taken;
   logic [NR_PORTS-1:0]           w_mp;
   logic [NR_PORTS-1:0]           w_exc;

   for (genvar i = 0; i < NR_PORTS; i++) begin : g_port
      logic [VLEN-1:0] w_pc;
      logic [VLEN-1:0] w_base;
      logic [VLEN-1:0] w_sum;
      logic [VLEN-1:0] w_target;
      logic [VLEN-1:0] w_pred_addr;
      logic [2:0]      w_pred_cf;
      logic [2:0]      w_cf_l;
      logic            w_mp_l;

      assign w_pc        = pc_i[i*VLEN +: VLEN];
      assign w_pred_addr = pred_addr_i[i*VLEN +: VLEN];
      assign w_pred_cf   = pred_cf_i[i*3 +: 3];
      assign w_base      = is_jalr_i[i] ? operand_a_i[i*VLEN +: VLEN] : w_pc;
      assign w_sum       = w_base + imm_i[i*VLEN +: VLEN];
      assign w_target    = is_jalr_i[i] ? {w_sum[VLEN-1:1], 1'b0} : w_sum;

      assign w_port_pc[i] = w_pc;
      assign w_next_pc[i] = w_pc + (is_compressed_i[i] ? VLEN'(2) : VLEN'(4));
      assign w_taken[i]   = comp_res_i[i] | is_jalr_i[i];
      assign w_res_tgt[i] = w_taken[i] ? w_target : w_next_pc[i];
      assign w_exc[i]     = w_taken[i] & w_target[0];
      assign w_cf[i]      = w_cf_l;
      assign w_mp[i]      = w_mp_l;

      // A JALR predicted as a return keeps that class so the RAS stays in step
      always_comb begin
         w_cf_l = w_pred_cf;
         w_mp_l = 1'b0;
         if (is_branch_i[i]) begin
            w_cf_l = c_CF_BRANCH;
            w_mp_l = w_taken[i] != (w_pred_cf == c_CF_BRANCH);
         end else if (is_jalr_i[i]) begin
            w_cf_l = (w_pred_cf == c_CF_RETURN) ? c_CF_RETURN : c_CF_JUMPR;
            w_mp_l = (w_pred_cf == c_CF_NOCF) || (w_target != w_pred_addr);
         end
      end

      assign result_o[i*VLEN +: VLEN] = w_next_pc[i];
   end

   // FIFO state
   logic [VLEN-1:0]    r_fifo_pc    [DEPTH];
   logic [VLEN-1:0]    r_fifo_tgt   [DEPTH];
   logic [2:0]         r_fifo_cf    [DEPTH];
   logic               r_fifo_taken [DEPTH];
   logic               r_fifo_mp    [DEPTH];
   logic               r_fifo_exc   [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_OCC_W-1:0] r_count;
   logic [CNT_W-1:0]   r_mp_cnt;

   logic [NR_PORTS-1:0]               w_push;
   logic [NR_PORTS-1:0][c_PTR_W-1:0]  w_slot;
   logic [c_OCC_W-1:0]                w_push_cnt;
   logic [c_NP_W-1:0]                 w_mp_add;
   logic                              w_stop;
   logic                              w_pop;
   logic [CNT_W:0]                    w_cnt_sum;

   assign ready_o     = ((c_OCC_W'(DEPTH) - r_count) >= c_OCC_W'(NR_PORTS)) & ~flush_i;
   assign res_valid_o = (r_count != '0);
   assign w_pop       = res_valid_o & res_ready_i & ~flush_i;

   // Ports enter in age order; the first redirecting one closes the group
   always_comb begin
      w_push     = '0;
      w_slot     = '0;
      w_push_cnt = '0;
      w_mp_add   = '0;
      w_stop     = 1'b0;
      for (int i = 0; i < NR_PORTS; i++) begin
         w_slot[i] = (r_wr_ptr + w_push_cnt[c_PTR_W-1:0]) & c_PTR_MASK;
         if (ready_o && valid_i[i] && !w_stop) begin
            w_push[i]  = 1'b1;
            w_push_cnt = w_push_cnt + c_OCC_W'(1);
            if (w_mp[i]) begin
               w_mp_add = w_mp_add + c_NP_W'(1);
            end
            if (w_mp[i] || w_exc[i]) begin
               w_stop = 1'b1;
            end
         end
      end
   end

   assign w_cnt_sum = {1'b0, r_mp_cnt} + {{(CNT_W + 1 - c_NP_W){1'b0}}, w_mp_add};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_mp_cnt <= '0;
         for (int d = 0; d < DEPTH; d++) begin
            r_fifo_pc[d]    <= '0;
            r_fifo_tgt[d]   <= '0;
            r_fifo_cf[d]    <= '0;
            r_fifo_taken[d] <= 1'b0;
            r_fifo_mp[d]    <= 1'b0;
            r_fifo_exc[d]   <= 1'b0;
         end
      end else begin
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            for (int i = 0; i < NR_PORTS; i++) begin
               if (w_push[i]) begin
                  r_fifo_pc[w_slot[i]]    <= w_port_pc[i];
                  r_fifo_tgt[w_slot[i]]   <= w_res_tgt[i];
                  r_fifo_cf[w_slot[i]]    <= w_cf[i];
                  r_fifo_taken[w_slot[i]] <= w_taken[i];
                  r_fifo_mp[w_slot[i]]    <= w_mp[i];
                  r_fifo_exc[w_slot[i]]   <= w_exc[i];
               end
            end
            r_wr_ptr <= (r_wr_ptr + w_push_cnt[c_PTR_W-1:0]) & c_PTR_MASK;
            if (w_pop) begin
               r_rd_ptr <= (r_rd_ptr + c_PTR_W'(1)) & c_PTR_MASK;
            end
            r_count <= r_count + w_push_cnt - c_OCC_W'(w_pop);
         end
         r_mp_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
   end

   // Head fields read as zero while the queue is empty
   assign res_pc_o         = res_valid_o ? r_fifo_pc[r_rd_ptr]    : '0;
   assign res_target_o     = res_valid_o ? r_fifo_tgt[r_rd_ptr]   : '0;
   assign res_cf_o         = res_valid_o ? r_fifo_cf[r_rd_ptr]    : '0;
   assign res_taken_o      = res_valid_o & r_fifo_taken[r_rd_ptr];
   assign res_mispredict_o = res_valid_o & r_fifo_mp[r_rd_ptr];
   assign res_exc_o        = res_valid_o & r_fifo_exc[r_rd_ptr];
   assign mispredict_cnt_o = r_mp_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_branch_resolve_queue                                       |
// | Purpose  : randomized + directed bench with a queue-based reference.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_queue;
   localparam int NR_PORTS = 2;
   localparam int DEPTH    = 4;
   localparam int VLEN     = 39;
   localparam int CNT_W    = 4;
   localparam logic [63:0] c_MASK    = (64'd1 << VLEN) - 64'd1;
   localparam logic [63:0] c_CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] tgt;
      logic [2:0]  cf;
      bit          taken;
      bit          mp;
      bit          exc;
      logic [63:0] next_pc;
      logic [63:0] raw_tgt;
   } ent_t;

   logic clk_i = 1'b0;
   logic rst_ni, flush_i, res_ready_i;
   logic ready_o, res_valid_o, res_taken_o, res_mispredict_o, res_exc_o;
   logic [NR_PORTS-1:0] valid_i, is_branch_i, is_jalr_i, comp_res_i, is_compressed_i;
   logic [NR_PORTS*VLEN-1:0] pc_i, operand_a_i, imm_i, pred_addr_i, result_o;
   logic [NR_PORTS*3-1:0] pred_cf_i;
   logic [VLEN-1:0] res_pc_o, res_target_o;
   logic [2:0] res_cf_o;
   logic [CNT_W-1:0] mispredict_cnt_o;

   // Per-port stimulus
   logic        s_valid [NR_PORTS];
   logic        s_br    [NR_PORTS];
   logic        s_jr    [NR_PORTS];
   logic        s_cmp   [NR_PORTS];
   logic        s_rvc   [NR_PORTS];
   logic [63:0] s_pc    [NR_PORTS];
   logic [63:0] s_opa   [NR_PORTS];
   logic [63:0] s_imm   [NR_PORTS];
   logic [2:0]  s_pcf   [NR_PORTS];
   logic [63:0] s_paddr [NR_PORTS];

   for (genvar g = 0; g < NR_PORTS; g++) begin : g_pack
      assign valid_i[g]         = s_valid[g];
      assign is_branch_i[g]     = s_br[g];
      assign is_jalr_i[g]       = s_jr[g];
      assign comp_res_i[g]      = s_cmp[g];
      assign is_compressed_i[g] = s_rvc[g];
      assign pc_i[g*VLEN +: VLEN]        = s_pc[g][VLEN-1:0];
      assign operand_a_i[g*VLEN +: VLEN] = s_opa[g][VLEN-1:0];
      assign imm_i[g*VLEN +: VLEN]       = s_imm[g][VLEN-1:0];
      assign pred_addr_i[g*VLEN +: VLEN] = s_paddr[g][VLEN-1:0];
      assign pred_cf_i[g*3 +: 3]         = s_pcf[g];
   end

   branch_resolve_queue #(
      .NR_PORTS(NR_PORTS), .DEPTH(DEPTH), .VLEN(VLEN), .CNT_W(CNT_W)
   ) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .is_branch_i(is_branch_i), .is_jalr_i(is_jalr_i),
      .comp_res_i(comp_res_i), .is_compressed_i(is_compressed_i),
      .pc_i(pc_i), .operand_a_i(operand_a_i), .imm_i(imm_i),
      .pred_cf_i(pred_cf_i), .pred_addr_i(pred_addr_i), .result_o(result_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_pc_o(res_pc_o), .res_target_o(res_target_o),
      .res_taken_o(res_taken_o), .res_mispredict_o(res_mispredict_o),
      .res_cf_o(res_cf_o), .res_exc_o(res_exc_o),
      .mispredict_cnt_o(mispredict_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_checks = 0;
   int   n_errors = 0;
   ent_t q[$];
   logic [63:0] m_cnt;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural meaning of one port's instruction
   function automatic ent_t resolve(input int p);
      ent_t        e;
      logic [63:0] base;
      e.pc      = s_pc[p];
      e.next_pc = (s_pc[p] + (s_rvc[p] ? 64'd2 : 64'd4)) & c_MASK;
      base      = s_jr[p] ? s_opa[p] : s_pc[p];
      e.raw_tgt = (base + s_imm[p]) & c_MASK;
      if (s_jr[p]) e.raw_tgt[0] = 1'b0;
      e.taken = s_cmp[p] || s_jr[p];
      e.tgt   = e.taken ? e.raw_tgt : e.next_pc;
      if (s_br[p]) begin
         e.cf = 3'd1;
         e.mp = e.taken != (s_pcf[p] == 3'd1);
      end else if (s_jr[p]) begin
         e.cf = (s_pcf[p] == 3'd4) ? 3'd4 : 3'd3;
         e.mp = (s_pcf[p] == 3'd0) || (e.raw_tgt != s_paddr[p]);
      end else begin
         e.cf = s_pcf[p];
         e.mp = 1'b0;
      end
      e.exc = e.taken && e.raw_tgt[0];
      return e;
   endfunction

   function automatic bit model_ready();
      return ((DEPTH - q.size()) >= NR_PORTS) && !flush_i;
   endfunction

   function automatic void model_clock();
      bit   rdy;
      int   add;
      ent_t e;
      rdy = model_ready();
      add = 0;
      if (flush_i) begin
         q.delete();
         return;
      end
      if (q.size() != 0 && res_ready_i) void'(q.pop_front());
      if (rdy) begin
         for (int p = 0; p < NR_PORTS; p++) begin
            if (s_valid[p]) begin
               e = resolve(p);
               q.push_back(e);
               if (e.mp) add++;
               if (e.mp || e.exc) break;
            end
         end
      end
      m_cnt = (m_cnt + 64'(add) > c_CNT_MAX) ? c_CNT_MAX : m_cnt + 64'(add);
   endfunction

   task automatic check_head(input string tag);
      check_eq({tag, "_valid"}, 64'(res_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
         check_eq({tag, "_pc"},    64'(res_pc_o),         q[0].pc);
         check_eq({tag, "_tgt"},   64'(res_target_o),     q[0].tgt);
         check_eq({tag, "_taken"}, 64'(res_taken_o),      64'(q[0].taken));
         check_eq({tag, "_mp"},    64'(res_mispredict_o), 64'(q[0].mp));
         check_eq({tag, "_cf"},    64'(res_cf_o),         64'(q[0].cf));
         check_eq({tag, "_exc"},   64'(res_exc_o),        64'(q[0].exc));
      end
      check_eq({tag, "_cnt"}, 64'(mispredict_cnt_o), m_cnt);
   endtask

   // Inputs are already applied at the falling edge when this is called
   task automatic step(input string tag);
      ent_t e;
      #1;
      check_eq({tag, "_ready"}, 64'(ready_o), 64'(model_ready()));
      for (int p = 0; p < NR_PORTS; p++) begin
         e = resolve(p);
         check_eq({tag, "_link"}, 64'(result_o[p*VLEN +: VLEN]), e.next_pc);
      end
      model_clock();
      @(posedge clk_i);
      @(negedge clk_i);
      check_head(tag);
   endtask

   task automatic drive_port(input int p, input bit v, input bit br, input bit jr,
                             input bit cmp, input logic [63:0] pc, input logic [63:0] opa,
                             input logic [63:0] imm, input logic [2:0] pcf,
                             input logic [63:0] paddr);
      s_valid[p] = v;   s_br[p]  = br;  s_jr[p]  = jr;   s_cmp[p] = cmp;
      s_rvc[p]   = 1'b0; s_pc[p] = pc;  s_opa[p] = opa;  s_imm[p] = imm;
      s_pcf[p]   = pcf; s_paddr[p] = paddr;
   endtask

   task automatic idle();
      for (int p = 0; p < NR_PORTS; p++) drive_port(p, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_port(input int p);
      logic [11:0] r12;
      int          kind;
      kind = $urandom_range(0, 2);
      r12  = 12'($urandom);
      s_valid[p] = ($urandom_range(0, 3) != 0);
      s_br[p]    = (kind == 0);
      s_jr[p]    = (kind == 1);
      s_cmp[p]   = 1'($urandom);
      s_rvc[p]   = 1'($urandom);
      s_pc[p]    = {$urandom, $urandom} & c_MASK;
      s_opa[p]   = {$urandom, $urandom} & c_MASK;
      s_imm[p]   = {{52{r12[11]}}, r12} & c_MASK;
      s_pcf[p]   = 3'($urandom_range(0, 4));
      s_paddr[p] = {$urandom, $urandom} & c_MASK;
      if (s_br[p] && $urandom_range(0, 1) == 1) s_pcf[p] = s_cmp[p] ? 3'd1 : 3'd0;
      if (s_jr[p] && $urandom_range(0, 1) == 1) s_paddr[p] = resolve(p).raw_tgt;
   endtask

   task automatic drain();
      idle();
      res_ready_i = 1'b1;
      for (int k = 0; k < DEPTH + 1; k++) step("drain");
   endtask

   logic [63:0] cnt_before;

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; res_ready_i = 1'b0;
      idle();
      q.delete(); m_cnt = 64'd0;
      @(posedge clk_i); @(negedge clk_i);
      check_eq("rst_valid", 64'(res_valid_o), 64'd0);
      check_eq("rst_cnt",   64'(mispredict_cnt_o), 64'd0);
      check_eq("rst_ready", 64'(ready_o), 64'd1);
      check_eq("rst_tgt",   64'(res_target_o), 64'd0);
      rst_ni = 1'b1;

      // Mispredicted taken branch predicted as no-CF
      drive_port(0, 1, 1, 0, 1, 64'h1000, 0, 64'h20, 3'd0, 0);
      step("br_mp");
      check_eq("br_mp_tgt_abs", 64'(res_target_o), 64'h1020);
      check_eq("br_mp_flag_abs", 64'(res_mispredict_o), 64'd1);
      check_eq("br_mp_cf_abs", 64'(res_cf_o), 64'd1);
      drain();

      // Correctly predicted JALR, then a not-taken branch in the same group
      res_ready_i = 1'b0;
      drive_port(0, 1, 0, 1, 0, 64'h4000, 64'h2003, 64'h0, 3'd3, 64'h2002);
      drive_port(1, 1, 1, 0, 0, 64'h4004, 0, 64'h40, 3'd0, 0);
      step("jalr");
      check_eq("jalr_tgt_abs", 64'(res_target_o), 64'h2002);
      check_eq("jalr_mp_abs", 64'(res_mispredict_o), 64'd0);
      idle(); res_ready_i = 1'b1;
      step("jalr_pop");
      check_eq("jalr_p1_pc_abs", 64'(res_pc_o), 64'h4004);
      drain();

      // A mispredict on port 0 discards port 1
      res_ready_i = 1'b0;
      drive_port(0, 1, 1, 0, 0, 64'h5000, 0, 64'h8, 3'd1, 0);
      drive_port(1, 1, 1, 0, 0, 64'h5004, 0, 64'h8, 3'd0, 0);
      step("grp_cut");
      idle(); res_ready_i = 1'b1;
      step("grp_cut_pop");
      check_eq("grp_cut_empty", 64'(res_valid_o), 64'd0);

      // Fill to DEPTH, then watch ready return only with NR_PORTS free
      res_ready_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive_port(0, 1, 1, 0, 0, 64'h6000 + 64'(8*k), 0, 64'h10, 3'd0, 0);
         drive_port(1, 1, 1, 0, 0, 64'h6004 + 64'(8*k), 0, 64'h10, 3'd0, 0);
         step("fill");
      end
      check_eq("full_ready", 64'(ready_o), 64'd0);
      idle(); res_ready_i = 1'b1;
      step("pop1");
      check_eq("one_free_ready", 64'(ready_o), 64'd0);
      step("pop2");
      check_eq("two_free_ready", 64'(ready_o), 64'd1);
      drain();

      // Misaligned taken target, then flush with three entries buffered
      res_ready_i = 1'b0;
      drive_port(0, 1, 1, 0, 1, 64'h1000, 0, 64'h3, 3'd1, 0);
      drive_port(1, 1, 1, 0, 0, 64'h1004, 0, 64'h3, 3'd0, 0);
      step("exc");
      check_eq("exc_abs", 64'(res_exc_o), 64'd1);
      check_eq("exc_tgt_abs", 64'(res_target_o), 64'h1003);
      drive_port(0, 1, 1, 0, 0, 64'h7000, 0, 64'h4, 3'd0, 0);
      drive_port(1, 1, 1, 0, 0, 64'h7004, 0, 64'h4, 3'd0, 0);
      step("pre_flush");
      cnt_before = m_cnt;
      flush_i = 1'b1; res_ready_i = 1'b1;
      step("flush");
      check_eq("flush_valid_abs", 64'(res_valid_o), 64'd0);
      check_eq("flush_cnt_kept", 64'(mispredict_cnt_o), cnt_before);
      flush_i = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         flush_i     = ($urandom_range(0, 19) == 0);
         res_ready_i = ($urandom_range(0, 2) != 0);
         for (int p = 0; p < NR_PORTS; p++) rand_port(p);
         step("rnd");
      end
      flush_i = 1'b0;

      // Asynchronous reset between clock edges with entries buffered
      idle(); res_ready_i = 1'b0;
      drive_port(0, 1, 1, 0, 1, 64'h8000, 0, 64'h10, 3'd0, 0);
      step("pre_rst");
      #2 rst_ni = 1'b0;
      #1;
      q.delete(); m_cnt = 64'd0;
      check_eq("arst_valid", 64'(res_valid_o), 64'd0);
      check_eq("arst_cnt",   64'(mispredict_cnt_o), 64'd0);
      check_eq("arst_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle();
      step("post_rst");

      // Counter saturation
      res_ready_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         drive_port(0, 1, 1, 0, 1, 64'h9000, 0, 64'h10, 3'd0, 0);
         step("sat");
      end
      check_eq("sat_cnt_abs", 64'(mispredict_cnt_o), c_CNT_MAX);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
